// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control unit: state-decoded datapath strobes, memory wait states with a
// stall timeout into a sticky ERROR state. Define MC_EXT_OPS_EN to add addi and j support.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            Op,
    input  logic [5:0]            Funct,
    input  logic                  MemReady,
    output logic                  PCWrite,
    output logic                  Branch,
    output logic                  IorD,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  MemtoReg,
    output logic                  RegDst,
    output logic                  RegWrite,
    output logic                  ALUSrcA,
    output logic                  Error,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            PCSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [3:0]            StateDbg
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [ALU_CTRL_W-1:0] CTRL_ADD = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] CTRL_SUB = ALU_CTRL_W'(3'b110);
    localparam logic [ALU_CTRL_W-1:0] CTRL_AND = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] CTRL_OR  = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] CTRL_SLT = ALU_CTRL_W'(3'b111);
    localparam logic [ALU_CTRL_W-1:0] CTRL_NOR = ALU_CTRL_W'(3'b100);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        ERROR    = 4'd15
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    is_wait;
    logic                    stall;
    logic                    funct_ok;
    logic [ALU_CTRL_W-1:0]   rtype_ctrl;

    assign is_wait  = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign stall    = is_wait && !MemReady;
    assign StateDbg = state;

    // The stall counter restarts whenever the state moves, so every access gets a full budget.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (stall) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        Error      = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = '0;
        funct_ok   = 1'b1;
        rtype_ctrl = '0;

        case (Funct)
            6'b100000: rtype_ctrl = CTRL_ADD;
            6'b100010: rtype_ctrl = CTRL_SUB;
            6'b100100: rtype_ctrl = CTRL_AND;
            6'b100101: rtype_ctrl = CTRL_OR;
            6'b101010: rtype_ctrl = CTRL_SLT;
            6'b100111: rtype_ctrl = CTRL_NOR;
            default:   funct_ok   = 1'b0;
        endcase

        case (state)
            FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = CTRL_ADD;
                IRWrite    = MemReady & rst_n;
                PCWrite    = MemReady & rst_n;
                if (MemReady) state_next = DECODE;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = CTRL_ADD;
                case (Op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
`ifdef MC_EXT_OPS_EN
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
`else
                    OP_ADDI, OP_J: state_next = ERROR;
`endif
                    default:      state_next = ERROR;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = CTRL_ADD;
                if (Op == OP_LW)      state_next = MEMREAD;
                else if (Op == OP_SW) state_next = MEMWRITE;
                else                  state_next = ERROR;
            end
            MEMREAD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (MemReady) state_next = MEMWB;
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) state_next = FETCH;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_ok ? rtype_ctrl : '0;
                state_next = funct_ok ? ALUWB : ERROR;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = CTRL_SUB;
                Branch     = 1'b1;
                PCSrc      = 2'b01;
                state_next = FETCH;
            end
`ifdef MC_EXT_OPS_EN
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = CTRL_ADD;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b10;
                state_next = FETCH;
            end
`endif
            ERROR: begin
                Error = 1'b1;
            end
            default: begin
                state_next = ERROR;
            end
        endcase

        // A wait state that has used its whole stall budget faults instead of holding again.
        if (stall && (wait_cnt == WAIT_LAST)) state_next = ERROR;
    end

endmodule
